// File: rtl/pes_div_pkg.sv
// Shared types and constants for the non-restoring divider.
package pes_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Replicated to WIDTH bits for the divide-by-zero quotient.
    localparam logic DBZ_Q_BIT = 1'b1;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/pes_nrd_step.sv
// One combinational non-restoring iteration: shift {A,Q}, add or subtract M, set a quotient bit.
module pes_nrd_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] a_nxt;

    always_comb begin
        a_sh  = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
        m_ext = {1'b0, m_i};
        // The sign of the old partial remainder selects add or subtract.
        if (a_i[WIDTH]) begin
            a_nxt = a_sh + m_ext;
        end else begin
            a_nxt = a_sh - m_ext;
        end
        a_o = a_nxt;
        q_o = {q_i[WIDTH-2:0], ~a_nxt[WIDTH]};
    end

endmodule

// File: rtl/pes_nrd_div.sv
// Sequential unsigned non-restoring divider: WIDTH iteration cycles plus one correction cycle.
module pes_nrd_div
    import pes_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH:0]   a_fix;

    pes_nrd_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a_i(a_q),
        .q_i(q_q),
        .m_i(m_q),
        .a_o(step_a),
        .q_o(step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        a_fix   = a_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quo_d  = {WIDTH{DBZ_Q_BIT}};
                        rem_d  = dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        a_d     = '0;
                        q_d     = dividend;
                        m_d     = divisor;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A negative final partial remainder is restored once by adding M back.
                if (a_q[WIDTH]) begin
                    a_fix = a_q + {1'b0, m_q};
                end
                a_d     = a_fix;
                quo_d   = q_q;
                rem_d   = a_fix[WIDTH-1:0];
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pes_nrd_div.sv
// Scoreboard bench for pes_nrd_div: driver queues expected results, monitor checks each done pulse.
module tb_pes_nrd_div;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int tests;
    int fails;
    exp_t sb[$];

    pes_nrd_div #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                check("done_busy_excl", int'(busy), 0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got q=%0d r=%0d, expected no result", quotient, remainder);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("quo %0d/%0d", e.a, e.b), int'(quotient), int'(e.q));
                    check($sformatf("rem %0d/%0d", e.a, e.b), int'(remainder), int'(e.r));
                    check($sformatf("dbz %0d/%0d", e.a, e.b), int'(div_by_zero), int'(e.z));
                    if (!e.z) begin
                        check($sformatf("invariant %0d/%0d", e.a, e.b),
                              int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
                        check($sformatf("rem_lt_div %0d/%0d", e.a, e.b),
                              int'(remainder < e.b), 1);
                    end
                end
            end
        end
    end

    task automatic push(input int a, input int b, input int q, input int r, input int z);
        exp_t e;
        e.a = W'(a);
        e.b = W'(b);
        e.q = W'(q);
        e.r = W'(r);
        e.z = z[0];
        sb.push_back(e);
    endtask

    // Presents one request for a single edge; leaves time at accept edge + 1.
    task automatic issue(input int a, input int b);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; reports edges after accept and busy samples seen.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = int'(busy);
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            bc += int'(busy);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no done after %0d cycles, expected done", lat);
        end
    endtask

    initial begin
        int lat;
        int bc;
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quo", int'(quotient), 0);
        check("rst_rem", int'(remainder), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 13/3 with latency and busy-length checks
        push(13, 3, 4, 1, 0);
        issue(13, 3);
        wait_done(lat, bc);
        check("lat_13_3", lat, W + 1);
        check("busy_13_3", bc, W + 1);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);

        // 7/9 then 15/1 started in the done cycle
        push(7, 9, 0, 7, 0);
        issue(7, 9);
        wait_done(lat, bc);
        check("done_before_b2b", int'(done), 1);
        push(15, 1, 15, 0, 0);
        issue(15, 1);
        check("b2b_accepted_busy", int'(busy), 1);
        wait_done(lat, bc);
        check("lat_15_1", lat, W + 1);

        // divide by zero: one-cycle latency, busy never set; next valid clears flag
        @(posedge clk);
        #1;
        push(9, 0, 15, 9, 1);
        issue(9, 0);
        wait_done(lat, bc);
        check("lat_dbz", lat, 0);
        check("busy_dbz", bc, 0);
        @(posedge clk);
        #1;
        push(12, 5, 2, 2, 0);
        issue(12, 5);
        wait_done(lat, bc);

        // start during RUN with changed operands is ignored
        @(posedge clk);
        #1;
        push(14, 4, 3, 2, 0);
        issue(14, 4);
        @(posedge clk);
        #1;
        dividend = 4'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd7;
        wait_done(lat, bc);
        repeat (8) @(posedge clk);
        #1;
        check("idle_after_ignore", int'(busy), 0);

        // reset on the third RUN cycle aborts; fresh 11/2 completes
        issue(11, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_quo", int'(quotient), 0);
        check("abort_rem", int'(remainder), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_idle", int'(busy), 0);
        push(11, 2, 5, 1, 0);
        issue(11, 2);
        wait_done(lat, bc);

        // boundaries
        @(posedge clk);
        #1;
        push(0, 5, 0, 0, 0);
        issue(0, 5);
        wait_done(lat, bc);
        @(posedge clk);
        #1;
        push(15, 15, 1, 0, 0);
        issue(15, 15);
        wait_done(lat, bc);

        // exhaustive sweep against the arithmetic reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(posedge clk);
                #1;
                if (b == 0) push(a, b, 15, a, 1);
                else        push(a, b, a / b, a % b, 0);
                issue(a, b);
                wait_done(lat, bc);
                check($sformatf("lat %0d/%0d", a, b), lat, (b == 0) ? 0 : W + 1);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
